// File: rtl/gf_sqrt.sv
// Sequential square root in GF(2^163) modulo x^163 + x^7 + x^6 + x^3 + 1.
// Root = A^(2^162), produced by iterating the field squaring map under a start/done handshake.
module gf_sqrt #(
  parameter int NUM_BITS     = 163,
  parameter int SQ_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_BITS:0]   A,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS:0]   Root
);

  localparam int ITERS = (NUM_BITS - 1) / SQ_PER_CYCLE;
  localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [NUM_BITS-1:0] w;
  logic [NUM_BITS-1:0] next_w;
  logic [CW-1:0]       cnt;
  logic                unused_msb;

  assign unused_msb = A[NUM_BITS];

  // Spread bits to even positions, then fold each high term down using x^163 = x^7 + x^6 + x^3 + 1.
  // Folding from the top means terms created above 162 are folded again later in the loop.
  function automatic logic [NUM_BITS-1:0] gf_sq(input logic [NUM_BITS-1:0] a);
    logic [2*NUM_BITS-2:0] p;
    p = '0;
    for (int i = 0; i < NUM_BITS; i++) begin
      p[2*i] = a[i];
    end
    for (int i = 2*NUM_BITS-2; i >= NUM_BITS; i--) begin
      if (p[i]) begin
        p[i]              = 1'b0;
        p[i-NUM_BITS+7]   = ~p[i-NUM_BITS+7];
        p[i-NUM_BITS+6]   = ~p[i-NUM_BITS+6];
        p[i-NUM_BITS+3]   = ~p[i-NUM_BITS+3];
        p[i-NUM_BITS]     = ~p[i-NUM_BITS];
      end
    end
    return p[NUM_BITS-1:0];
  endfunction

  always_comb begin
    next_w = w;
    for (int k = 0; k < SQ_PER_CYCLE; k++) begin
      next_w = gf_sq(next_w);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      w     <= '0;
      cnt   <= '0;
      Root  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            w     <= A[NUM_BITS-1:0];
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          w   <= next_w;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            Root  <= {1'b0, next_w};
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/gf_sqrt.md
# gf_sqrt

Sequential square-root unit for GF(2^163) with the NIST B-163/K-163 pentanomial f(x) = x^163 + x^7 + x^6 + x^3 + 1, the inverse of the combinational squarer gf_Square. It computes Root = A^(2^162), which is the unique value with Root^2 = A mod f, by iterating the squaring map under a start/done handshake. It uses the same 164-bit operand format as gf_Square and sits beside it in the ECC point-arithmetic datapath, where it serves point compression/decompression and half-trace steps.

## Interface
- NUM_BITS, 163, field degree; operands are [NUM_BITS:0], 164 bits.
- SQ_PER_CYCLE, 1, squarings applied per RUN cycle; legal values are divisors of 162 (1, 2, 3, 6, 9, 18, 27, 54, 81, 162).
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- A  in  164  operand; bit 163 is ignored and treated as 0; bits [162:0] are the field element.
- busy  out  1  high while the computation is in progress.
- done  out  1  single-cycle completion pulse.
- Root  out  164  result; bit 163 is always 0; held stable outside RUN.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start = 1.
  - RUN -> DONE when iteration counter == L-1, with L = 162/SQ_PER_CYCLE.
  - DONE -> IDLE unconditionally.
- IDLE with start:
  - Latch A[162:0] into the working register W.
  - Clear the counter to 0.
- RUN, each cycle:
  - W <= S^SQ_PER_CYCLE(W), where S is one GF squaring.
  - Counter increments.
  - On the final RUN cycle, Root <= {1'b0, next W}.
- One squaring S:
  - Interleave zeros: bit i of W goes to bit 2i of a 325-bit product.
  - Reduce modulo f by folding bits 324..163 via x^163 = x^7 + x^6 + x^3 + 1.
  - Fold high to low until the degree is at most 162.
  - Must be bit-exact with gf_Square for every input with bit 163 = 0.
- Counter width is ceil(log2(L)) bits, minimum 1; there is no wrap within a computation.
- start outside IDLE (RUN or DONE) is ignored; no queuing.
- A may change freely after the start cycle; only the latched value is used.
- Root keeps the last result until the final RUN cycle of the next computation; it is not updated mid-run.
- Reset:
  - Reset values: state=IDLE, W=0, counter=0, Root=0, busy=0, done=0.
  - Reset asserted mid-RUN aborts the computation; Root returns to 0 and no done pulse is produced.
  - Reset has priority over start in the same cycle.
- Edge inputs:
  - A=0 yields 0.
  - A=1 yields 1.
  - No input is illegal.

## Timing
- Edge E0 samples start=1 in IDLE.
- busy=1 after edge E0 through the end of the final RUN cycle: exactly L cycles (162 for SQ_PER_CYCLE=1, 54 for 3).
- Root and done update on edge E_L. done=1 for exactly the one cycle after E_L, in DONE, with busy=0.
- Earliest next accepted start is the cycle after DONE, i.e. sampled at edge E_(L+2).
- Minimum start-to-start period: L+2 cycles.
- busy and done are never high together.
- The combinational depth of S^SQ_PER_CYCLE sets Fmax; SQ_PER_CYCLE=1 is the default.

## Test plan
- Reset then idle: hold rst 3 cycles with start=1 -> Root=0, busy=0, done=0; with start still high, busy rises on the first edge after rst drops.
- Basic: A=164'h4 (x^2), SQ_PER_CYCLE=1 -> done pulse exactly 162 cycles after the start edge, Root=164'h2; A=0 -> Root=0; A=1 -> Root=1.
- High-degree operands:
  - A = 1<<162 -> Root = 1<<81.
  - A = (1<<160) | 4 -> Root = (1<<80) | 2.
  - A with bit 163 set plus 1<<162 -> same as without bit 163, Root = 1<<81.
- Random round-trip: 200 random 163-bit A values -> gf_Square(Root) == A; start pulses held during RUN/DONE are ignored; the done count equals the accepted-start count.
- Unrolled: SQ_PER_CYCLE=3 and 162 with the same vectors -> identical Root; done at 54 and 1 cycles respectively.
- Abort: assert rst at cycle 80 of a run -> no done pulse, Root=0, state IDLE; a fresh start then completes normally with the correct Root.
